// File: rtl/scope_pkg.sv
// scope_pkg: shared types for the scope_trigger capture block.
//   scope_state_t : capture state machine encoding
//   edge_t        : trigger slope selection (RISE / FALL)
package scope_pkg;

    typedef enum logic [2:0] {
        S_FILL,
        S_ARMED,
        S_POST,
        S_DUMP,
        S_HOLDOFF
    } scope_state_t;

    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } edge_t;

endpackage

// File: rtl/scope_ram.sv
// scope_ram: simple dual-port RAM, one write port and one registered read
// port on the same clock. Contents and read register are not reset.
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read strobe (rd_data updates one cycle later)
//   rd_addr  in  read address
//   rd_data  out registered read data
module scope_ram #(
    parameter int W     = 10,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scope_trigger.sv
// scope_trigger: oscilloscope-style edge trigger with pre-trigger capture.
// Samples stream into a circular buffer; after an edge trigger (with
// hysteresis) the frame of DEPTH samples, PRE of them before the trigger,
// is replayed on the output, followed by a hold-off period.
// Optional feature: define SCOPE_TRIGGER_AUTO_EN to build the auto-trigger
// timeout (TIMEOUT accepted samples in ARMED forces a trigger when auto=1).
// Ports:
//   clkSmpl   in  sample clock
//   n_reset   in  asynchronous active-low reset
//   in_data   in  N-bit unsigned sample,  in_valid in sample strobe
//   level     in  trigger level,  hyst in hysteresis
//   fall      in  0 = rising edge, 1 = falling edge
//   auto      in  auto-trigger enable
//   out_data  out frame sample,  out_valid out strobe
//   out_start out first sample of frame
//   busy      out high in DUMP/HOLDOFF
//   forced    out last frame was auto-triggered
module scope_trigger
    import scope_pkg::*;
#(
    parameter int N       = 10,
    parameter int DEPTH   = 512,
    parameter int PRE     = 64,
    parameter int HOLDOFF = 1024,
    parameter int TIMEOUT = 2**20
) (
    input  logic         clkSmpl,
    input  logic         n_reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    input  logic [N-1:0] level,
    input  logic [N-1:0] hyst,
    input  logic         fall,
    input  logic         auto,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         out_start,
    output logic         busy,
    output logic         forced
);

    localparam int AW     = $clog2(DEPTH);
    localparam int POST_N = DEPTH - PRE - 1;
    localparam int MAXC   = (DEPTH > HOLDOFF) ? DEPTH : HOLDOFF;
    localparam int CW     = $clog2(MAXC + 1) + 1;

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(POST_N - 1);
    localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF);
    localparam logic [AW-1:0] PRE_A      = AW'(PRE);

    scope_state_t  state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] wptr, tptr, rd_addr;
    logic          arm, arm_nx;
    logic          forced_nx;
    logic          fire;
    logic          accept;
    logic          rd_en;
    logic [N-1:0]  rd_data;
    logic [N:0]    lo_ext, hi_ext;
    logic [N-1:0]  lo_th, hi_th;
    logic          arm_cond, trig_cond;
    logic          timeout_hit;
    edge_t         mode;

    assign accept = in_valid && (state == S_FILL || state == S_ARMED || state == S_POST);

    // Thresholds saturate instead of wrapping at the ends of the sample range.
    assign lo_ext = {1'b0, level} - {1'b0, hyst};
    assign hi_ext = {1'b0, level} + {1'b0, hyst};
    assign lo_th  = lo_ext[N] ? '0 : lo_ext[N-1:0];
    assign hi_th  = hi_ext[N] ? '1 : hi_ext[N-1:0];
    assign mode   = fall ? FALL : RISE;

    always_comb begin
        arm_cond  = 1'b0;
        trig_cond = 1'b0;
        case (mode)
            RISE: begin
                arm_cond  = in_data < lo_th;
                trig_cond = in_data >= level;
            end
            FALL: begin
                arm_cond  = in_data > hi_th;
                trig_cond = in_data <= level;
            end
            default: ;
        endcase
    end

`ifdef SCOPE_TRIGGER_AUTO_EN
    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;

    // Counts accepted ARMED samples, saturating so that enabling auto late
    // still fires on the next sample once the timeout has elapsed.
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset)
            tcnt <= '0;
        else if (state != S_ARMED)
            tcnt <= '0;
        else if (accept && tcnt != TMAX)
            tcnt <= tcnt + 1'b1;
    end

    assign timeout_hit = auto && (tcnt == TMAX);
`else
    logic unused_auto;
    assign unused_auto = auto;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        arm_nx    = arm;
        forced_nx = forced;
        fire      = 1'b0;
        case (state)
            S_FILL: begin
                if (accept) begin
                    if (cnt == PRE_LAST) begin
                        state_nx = S_ARMED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (accept) begin
                    if ((arm && trig_cond) || timeout_hit) begin
                        fire      = 1'b1;
                        forced_nx = !(arm && trig_cond);
                        arm_nx    = 1'b0;
                        cnt_nx    = '0;
                        state_nx  = (POST_N == 0) ? S_DUMP : S_POST;
                    end else if (arm_cond) begin
                        arm_nx = 1'b1;
                    end
                end
            end
            S_POST: begin
                if (accept) begin
                    if (cnt == POST_LAST) begin
                        state_nx = S_DUMP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_DUMP: begin
                if (cnt == DEPTH_LAST) begin
                    state_nx = S_HOLDOFF;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_HOLDOFF: begin
                // The first HOLDOFF cycle carries the last out_valid, so the
                // count runs one past HOLDOFF before re-arming.
                if (cnt == HOLD_LAST) begin
                    state_nx = S_FILL;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_FILL;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_FILL;
            cnt       <= '0;
            arm       <= 1'b0;
            forced    <= 1'b0;
            wptr      <= '0;
            tptr      <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            arm       <= arm_nx;
            forced    <= forced_nx;
            if (accept)
                wptr <= wptr + 1'b1;
            if (fire)
                tptr <= wptr;
            out_valid <= rd_en;
            out_start <= rd_en && (cnt == '0);
        end
    end

    assign rd_en   = (state == S_DUMP);
    assign rd_addr = tptr - PRE_A + cnt[AW-1:0];

    scope_ram #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clkSmpl),
        .wr_en   (accept),
        .wr_addr (wptr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign out_data = out_valid ? rd_data : '0;
    assign busy     = (state == S_DUMP) || (state == S_HOLDOFF);

endmodule
